lif_sweep_scheduler: RTL and testbench

Time-multiplexes one shared leaky-integrate-and-fire update datapath across `N_NEURONS` virtual neurons. It holds each neuron's membrane voltage and refractory count in local registers. On each global `tick` it sweeps all neurons in index order, one update per cycle. Spikes leave through a valid/ready event port. The block sits between the synapse-input fabric and the spike router, and replaces per-neuron LIF instances in larger arrays.

---
 rtl/lif_sweep_scheduler_pkg.sv | 15 +
 rtl/lif_sweep_scheduler_if.sv | 33 +++
 rtl/lif_sweep_scheduler_core.sv | 45 ++++
 rtl/lif_sweep_scheduler.sv | 120 ++++++++++++
 tb/tb_lif_sweep_scheduler.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/lif_sweep_scheduler_pkg.sv
// Shared types and widths for the time-multiplexed LIF sweep scheduler.
package lif_pkg;

    localparam int LIF_VW = 8;
    localparam int TAU_W  = 3;
    localparam int LIF_RW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } lif_sched_state_t;

endpackage

// File: rtl/lif_sweep_scheduler_if.sv
// Control, parameter, spike-event and debug-read bundle of the LIF sweep scheduler.
interface lif_sweep_scheduler_if
    import lif_pkg::*;
#(
    parameter int N_NEURONS = 16
);
    localparam int IW = $clog2(N_NEURONS);

    logic                 tick;
    logic [N_NEURONS-1:0] syn_in;
    logic [LIF_VW-1:0]    weight;
    logic [LIF_VW-1:0]    threshold;
    logic [TAU_W-1:0]     tau_shift;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    logic                 spike_valid;
    logic                 spike_ready;
    logic [IW-1:0]        spike_id;
    logic [IW-1:0]        v_rd_addr;
    logic [LIF_VW-1:0]    v_rd_data;

    modport master (
        output tick, syn_in, weight, threshold, tau_shift, spike_ready, v_rd_addr,
        input  busy, done, overrun, spike_valid, spike_id, v_rd_data
    );

    modport slave (
        input  tick, syn_in, weight, threshold, tau_shift, spike_ready, v_rd_addr,
        output busy, done, overrun, spike_valid, spike_id, v_rd_data
    );

endinterface

// File: rtl/lif_sweep_scheduler_core.sv
// Combinational leaky-integrate-and-fire update for one neuron; shared by the
// serial scheduler and intended for reuse by parallel-lane variants.
module lif_update_core
    import lif_pkg::*;
#(
    parameter int unsigned REFRAC_TICKS = 2
) (
    input  logic [LIF_VW-1:0] v_i,
    input  logic [LIF_RW-1:0] refrac_i,
    input  logic              syn_i,
    input  logic [LIF_VW-1:0] weight_i,
    input  logic [LIF_VW-1:0] threshold_i,
    input  logic [TAU_W-1:0]  tau_shift_i,
    output logic [LIF_VW-1:0] v_next_o,
    output logic [LIF_RW-1:0] refrac_next_o,
    output logic              fire_o
);

    localparam logic [LIF_RW-1:0] REFRAC_INIT = LIF_RW'(REFRAC_TICKS);

    logic [LIF_VW-1:0] leak_s;
    logic [LIF_VW-1:0] vl_s;
    logic [LIF_VW:0]   sum_s;
    logic [LIF_VW-1:0] sum_sat_s;

    // Leak, integrate with saturation, then threshold; refractory neurons ignore input.
    always_comb begin
        leak_s        = v_i >> tau_shift_i;
        vl_s          = v_i - leak_s;
        sum_s         = {1'b0, vl_s} + (syn_i ? {1'b0, weight_i} : {(LIF_VW+1){1'b0}});
        sum_sat_s     = sum_s[LIF_VW] ? {LIF_VW{1'b1}} : sum_s[LIF_VW-1:0];
        v_next_o      = {LIF_VW{1'b0}};
        refrac_next_o = {LIF_RW{1'b0}};
        fire_o        = 1'b0;
        if (refrac_i != {LIF_RW{1'b0}}) begin
            refrac_next_o = refrac_i - {{(LIF_RW-1){1'b0}}, 1'b1};
        end else if (sum_sat_s >= threshold_i) begin
            refrac_next_o = REFRAC_INIT;
            fire_o        = 1'b1;
        end else begin
            v_next_o      = sum_sat_s;
        end
    end

endmodule

// File: rtl/lif_sweep_scheduler.sv
// Sweeps N_NEURONS virtual LIF neurons through one shared update core per tick,
// emitting spikes on a valid/ready port.
module lif_sweep_scheduler
    import lif_pkg::*;
#(
    parameter int N_NEURONS    = 16,
    parameter int REFRAC_TICKS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    lif_sweep_scheduler_if.slave  bus
);

    localparam int            IW   = $clog2(N_NEURONS);
    localparam logic [IW-1:0] LAST = IW'(N_NEURONS - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    lif_sched_state_t     state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [N_NEURONS-1:0] snap_q, snap_d;
    logic                 overrun_q, overrun_d;
    logic [LIF_VW-1:0]    v_rd_q;
    logic [LIF_VW-1:0]    v_q      [N_NEURONS];
    logic [LIF_RW-1:0]    refrac_q [N_NEURONS];

    logic [LIF_VW-1:0]    upd_v_s;
    logic [LIF_RW-1:0]    upd_refrac_s;
    logic                 upd_fire_s;

    lif_update_core #(.REFRAC_TICKS(REFRAC_TICKS)) u_core (
        .v_i           (v_q[idx_q]),
        .refrac_i      (refrac_q[idx_q]),
        .syn_i         (snap_q[idx_q]),
        .weight_i      (bus.weight),
        .threshold_i   (bus.threshold),
        .tau_shift_i   (bus.tau_shift),
        .v_next_o      (upd_v_s),
        .refrac_next_o (upd_refrac_s),
        .fire_o        (upd_fire_s)
    );

    // Sweep sequencing, tick snapshot and overrun detection.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        overrun_d = overrun_q | (bus.tick & (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (bus.tick) begin
                    state_d = UPDATE;
                    idx_d   = {IW{1'b0}};
                    snap_d  = bus.syn_in;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                if (upd_fire_s) begin
                    state_d = EMIT;
                end else if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ONE;
                end
            end
            EMIT: begin
                if (!bus.spike_ready) begin
                    state_d = EMIT;
                end else if (idx_q == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d = UPDATE;
                    idx_d   = idx_q + ONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control registers and the one-cycle debug read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= {IW{1'b0}};
            snap_q    <= {N_NEURONS{1'b0}};
            overrun_q <= 1'b0;
            v_rd_q    <= {LIF_VW{1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            overrun_q <= overrun_d;
            v_rd_q    <= v_q[bus.v_rd_addr];
        end
    end

    // Neuron state is written back at the end of that neuron's UPDATE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]      <= {LIF_VW{1'b0}};
                refrac_q[i] <= {LIF_RW{1'b0}};
            end
        end else if (state_q == UPDATE) begin
            v_q[idx_q]      <= upd_v_s;
            refrac_q[idx_q] <= upd_refrac_s;
        end
    end

    // Outputs decode registered state only, so they cannot glitch or move under backpressure.
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.spike_valid = (state_q == EMIT);
    assign bus.spike_id    = idx_q;
    assign bus.overrun     = overrun_q;
    assign bus.v_rd_data   = v_rd_q;

endmodule

// File: tb/tb_lif_sweep_scheduler.sv
// Directed bench for lif_sweep_scheduler: N=4 functional scenarios and N=16 sweep timing.
module tb_lif_sweep_scheduler;
    import lif_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lif_sweep_scheduler_if #(.N_NEURONS(4))  b4  ();
    lif_sweep_scheduler_if #(.N_NEURONS(16)) b16 ();

    lif_sweep_scheduler #(.N_NEURONS(4), .REFRAC_TICKS(2)) dut4 (
        .clk (clk), .rst (rst), .bus (b4.slave)
    );
    lif_sweep_scheduler #(.N_NEURONS(16), .REFRAC_TICKS(2)) dut16 (
        .clk (clk), .rst (rst), .bus (b16.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int spk_q[$];
    int done_hs;
    logic [7:0] rd;
    int cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd4(input logic [1:0] a, output logic [7:0] d);
        b4.v_rd_addr = a;
        step();
        d = b4.v_rd_data;
    endtask

    // Collect handshaked spikes until done (bounded), then step into IDLE.
    task automatic collect4();
        logic seen;
        seen    = 1'b0;
        done_hs = -1;
        spk_q.delete();
        for (int k = 0; k < 60; k++) begin
            if (b4.spike_valid && b4.spike_ready) spk_q.push_back(32'(b4.spike_id));
            if (b4.done) begin
                seen    = 1'b1;
                done_hs = spk_q.size();
                break;
            end
            step();
        end
        check("done_seen", 32'(seen), 32'd1);
        step();
    endtask

    task automatic sweep4(input logic [3:0] syn);
        b4.syn_in = syn;
        b4.tick   = 1'b1;
        step();
        b4.tick   = 1'b0;
        collect4();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        b4.tick = 1'b0; b4.syn_in = 4'b0; b4.weight = 8'd10; b4.threshold = 8'd25;
        b4.tau_shift = 3'd3; b4.spike_ready = 1'b1; b4.v_rd_addr = 2'd0;
        b16.tick = 1'b0; b16.syn_in = 16'b0; b16.weight = 8'd0; b16.threshold = 8'd255;
        b16.tau_shift = 3'd3; b16.spike_ready = 1'b1; b16.v_rd_addr = 4'd0;
        step(); step(); step();
        rst = 1'b0;

        check("rst_busy",    32'(b4.busy),        32'd0);
        check("rst_done",    32'(b4.done),        32'd0);
        check("rst_overrun", 32'(b4.overrun),     32'd0);
        check("rst_valid",   32'(b4.spike_valid), 32'd0);
        check("rst_id",      32'(b4.spike_id),    32'd0);
        check("rst_vrd",     32'(b4.v_rd_data),   32'd0);

        // Integrate with leak: 10, 19, then 27 >= 25 fires.
        sweep4(4'b0001);
        check("t1_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("t1_v0", 32'(rd), 32'd10);
        sweep4(4'b0001);
        check("t2_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("t2_v0", 32'(rd), 32'd19);
        sweep4(4'b0001);
        check("t3_spikes", 32'(spk_q.size()), 32'd1);
        if (spk_q.size() > 0) check("t3_id", 32'(spk_q[0]), 32'd0);
        rd4(2'd0, rd); check("t3_v0", 32'(rd), 32'd0);
        for (int i = 1; i < 4; i++) begin
            rd4(2'(i), rd); check("t3_vother", 32'(rd), 32'd0);
        end

        // Two refractory ticks discard input, then integration resumes.
        sweep4(4'b0001);
        check("rf1_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("rf1_v0", 32'(rd), 32'd0);
        sweep4(4'b0001);
        check("rf2_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("rf2_v0", 32'(rd), 32'd0);
        sweep4(4'b0001);
        check("rf3_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("rf3_v0", 32'(rd), 32'd10);

        // threshold=0: every neuron fires; hold ready low on the first spike.
        b4.threshold = 8'd0; b4.syn_in = 4'b1111; b4.spike_ready = 1'b0;
        b4.tick = 1'b1; step(); b4.tick = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(b4.spike_valid), 32'd1);
            check("bp_id",    32'(b4.spike_id),    32'd0);
            check("bp_done",  32'(b4.done),        32'd0);
            step();
        end
        b4.spike_ready = 1'b1;
        collect4();
        check("bp_count", 32'(spk_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < spk_q.size(); i++) check("bp_order", 32'(spk_q[i]), 32'(i));
        check("bp_done_after", 32'(done_hs), 32'd4);

        // Let refractory counts expire.
        b4.threshold = 8'd255;
        sweep4(4'b0000); check("clr1_spikes", 32'(spk_q.size()), 32'd0);
        sweep4(4'b0000); check("clr2_spikes", 32'(spk_q.size()), 32'd0);

        // Saturation: 200, then 199+200 clamps to 255 and fires (wrap would give 143).
        b4.weight = 8'd200; b4.tau_shift = 3'd7;
        sweep4(4'b0001);
        check("sat1_spikes", 32'(spk_q.size()), 32'd0);
        rd4(2'd0, rd); check("sat1_v0", 32'(rd), 32'd200);
        sweep4(4'b0001);
        check("sat2_spikes", 32'(spk_q.size()), 32'd1);
        if (spk_q.size() > 0) check("sat2_id", 32'(spk_q[0]), 32'd0);
        rd4(2'd0, rd); check("sat2_v0", 32'(rd), 32'd0);

        // Overrun: tick again at cycle 2, sweep still ends at cycle 5.
        b4.weight = 8'd10; b4.tau_shift = 3'd3; b4.syn_in = 4'b0100;
        check("ovr_before", 32'(b4.overrun), 32'd0);
        b4.tick = 1'b1; step(); b4.tick = 1'b0;
        step();
        b4.tick = 1'b1; step(); b4.tick = 1'b0;
        cyc = 3;
        check("ovr_set", 32'(b4.overrun), 32'd1);
        while (!b4.done && cyc < 30) begin
            step();
            cyc++;
        end
        check("ovr_done_cycle", 32'(cyc), 32'd5);
        step();
        rd4(2'd2, rd); check("ovr_v2", 32'(rd), 32'd10);

        // Reset mid-EMIT: neuron0 still refractory, neuron1 fires at threshold 0.
        b4.threshold = 8'd0; b4.syn_in = 4'b0000; b4.spike_ready = 1'b0;
        b4.tick = 1'b1; step(); b4.tick = 1'b0;
        cyc = 1;
        while (!b4.spike_valid && cyc < 10) begin
            step();
            cyc++;
        end
        check("emit_valid", 32'(b4.spike_valid), 32'd1);
        check("emit_id",    32'(b4.spike_id),    32'd1);
        check("emit_cycle", 32'(cyc),            32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_busy",    32'(b4.busy),        32'd0);
        check("abort_valid",   32'(b4.spike_valid), 32'd0);
        check("abort_overrun", 32'(b4.overrun),     32'd0);
        check("abort_id",      32'(b4.spike_id),    32'd0);
        check("abort_vrd",     32'(b4.v_rd_data),   32'd0);
        rd4(2'd2, rd); check("abort_v2", 32'(rd), 32'd0);
        b4.spike_ready = 1'b1;

        // N=16 no-spike timing: busy 1..17, done at 17, tick at 18 accepted.
        b16.tick = 1'b1; step(); b16.tick = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            check("n16_busy", 32'(b16.busy), 32'((c <= 17) ? 1 : 0));
            check("n16_done", 32'(b16.done), 32'((c == 17) ? 1 : 0));
            if (c < 18) step();
        end
        b16.tick = 1'b1; step(); b16.tick = 1'b0;
        check("n16_retick", 32'(b16.busy), 32'd1);
        check("n16_no_ovr", 32'(b16.overrun), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
